axis_reg_slice: RTL and testbench
=================================

AXIS_REG_SLICE -- requirements
Module: axis_reg_slice

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, tdata width in bits; multiple of 8, elaboration error otherwise.
REQ-002 SHALL have parameter ID_WIDTH, default 4, tid width.
REQ-003 SHALL have parameter DEST_WIDTH, default 1, tdest width.
REQ-004 SHALL have parameter USER_WIDTH, default 4, tuser width.
REQ-005 SHALL have parameter STAGES, default 1, number of cascaded skid stages; legal range 0..8, elaboration error otherwise.
REQ-006 SHALL have port aclk  input  1  sole clock; one clock, all logic on rising edge.
REQ-007 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port s_axis  axistream_if.slave  DWIDTH/ID/DEST/USER per parameters  upstream stream; tready driven by this block.
REQ-009 SHALL have port m_axis  axistream_if.master  same widths  downstream stream.
REQ-010 SHALL have port level  output  $clog2(2*STAGES+1), min 1  beats currently held in the block.

Function
REQ-011 Payload SHALL be the full beat {tdata, tstrb (DWIDTH/8), tkeep (DWIDTH/8), tlast, tid, tdest, tuser}, carried unmodified as one unit.
REQ-012 Transfer definitions: s_fire = s_axis.tvalid & s_axis.tready; m_fire = m_axis.tvalid & m_axis.tready.
REQ-013 STAGES=0 SHALL be a pure wire-through: every field and tready connected combinationally, zero latency, level tied to 0.
REQ-014 STAGES>=1: each stage SHALL hold a main register and a skid register, with state EMPTY, ONE or TWO.
REQ-015 Stage transitions, with in_fire/out_fire taken at that stage's input/output:
- EMPTY+in -> ONE, load main.
- ONE+in+!out -> TWO, load skid.
- ONE+!in+out -> EMPTY.
- ONE+in+out -> ONE, main loads the new beat.
- TWO+out -> ONE, main <= skid.
- No event -> hold.
REQ-016 Each stage tvalid SHALL be (state != EMPTY) and its output payload SHALL be the main register.
REQ-017 Each stage tready SHALL be a flop: 0 in reset, else (next_state != TWO); no combinational path from m_axis.tready to s_axis.tready.
REQ-018 Stage k output SHALL feed stage k+1 input; stage 0 input is s_axis and stage STAGES-1 output is m_axis.
REQ-019 Latency SHALL be STAGES cycles from s_fire to first possible m_axis.tvalid.
REQ-020 With m_axis.tready held 1, throughput SHALL be one beat per cycle with no bubbles.
REQ-021 Capacity SHALL be 2*STAGES beats; with downstream stalled, s_axis.tready deasserts the cycle after the 2*STAGES-th accept.
REQ-022 While m_axis.tvalid=1 and m_axis.tready=0, all m_axis payload fields SHALL stay stable.
REQ-023 Beats SHALL never be dropped, duplicated or reordered; tlast/tid/tdest/tuser stay bound to their beat.
REQ-024 level SHALL be a register: +1 on s_fire only, -1 on m_fire only, unchanged on both or neither; never exceeds 2*STAGES.
REQ-025 s_axis inputs SHALL be ignored when s_axis.tready=0.

Reset
REQ-026 While areset=1 at a rising edge: all stages -> EMPTY, m_axis.tvalid=0, s_axis.tready=0, level=0.
REQ-027 s_axis.tready SHALL rise on the first rising edge with areset=0.
REQ-028 Payload registers SHALL NOT be reset; their contents are don't-care while tvalid=0.
REQ-029 Reset asserted mid-stream SHALL discard all held beats; no pre-reset beat appears on m_axis afterward.

Verification
REQ-030 Reset: areset=1 for 3 cycles, s tvalid=1 -> m tvalid=0, s tready=0, level=0; s tready=1 one cycle after release.
REQ-031 Streaming, STAGES=2, m tready=1: 16 beats, tdata 0..15, tlast on 15 -> first beat out 2 cycles after first accept, then one per cycle, in order, tlast on 15 only.
REQ-032 Backpressure, STAGES=1, m tready=0: offer A,B,C -> A,B accepted, s tready=0 from the cycle after B, level=2, C held. Raise m tready -> A,B,C out in order; level returns to 0.
REQ-033 Random, STAGES in {1,3,8}: random tvalid/tready, 10000 beats, all fields random -> scoreboard exact match, payload stable under stall, level equals the model count every cycle.
REQ-034 Mid-op reset, STAGES=2: with level=3, pulse areset 1 cycle -> next cycle m tvalid=0, level=0. Post-reset beats 0xA0..0xA3 out exactly, no stale data.
REQ-035 Wire-through, STAGES=0: toggle m tready -> s tready follows the same cycle; every field matches with zero latency.

Source files
------------

// File: rtl/axis_reg_slice_if.sv
// AXI4-Stream bundle shared by the register slice and its neighbours.
// Handshake: a beat transfers on a rising edge where tvalid and tready are both 1;
// once tvalid is raised the master holds it and every payload field until that edge.
interface axistream_if #(
  parameter int DWIDTH     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 4
);
  logic                    tvalid;
  logic                    tready;
  logic [DWIDTH-1:0]       tdata;
  logic [DWIDTH/8-1:0]     tstrb;
  logic [DWIDTH/8-1:0]     tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_reg_slice.sv
// Cascade of skid-buffer stages cutting every combinational path of an AXI4-Stream;
// each stage registers tvalid, tready and the payload, and holds up to two beats.
module axis_reg_slice #(
  parameter int DWIDTH     = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 4,
  parameter int STAGES     = 1,
  localparam int LEVEL_W   = (STAGES > 0) ? $clog2(2 * STAGES + 1) : 1
) (
  input  logic               aclk,
  input  logic               areset,
  axistream_if.slave         s_axis,
  axistream_if.master        m_axis,
  output logic [LEVEL_W-1:0] level
);
  localparam int KW = DWIDTH / 8;
  localparam int PW = DWIDTH + 2 * KW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  if (DWIDTH < 8 || (DWIDTH % 8) != 0) begin : g_bad_dwidth
    $error("axis_reg_slice: DWIDTH must be a positive multiple of 8");
  end
  if (STAGES < 0 || STAGES > 8) begin : g_bad_stages
    $error("axis_reg_slice: STAGES must lie in 0..8");
  end

  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;

  // The whole beat travels as one vector so sideband fields can never detach from their data.
  assign in_payload = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                       s_axis.tid, s_axis.tdest, s_axis.tuser};
  assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = out_payload;

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = aclk | areset;
    assign out_payload    = in_payload;
    assign m_axis.tvalid  = s_axis.tvalid;
    assign s_axis.tready  = m_axis.tready;
    assign level          = '0;
  end else begin : g_pipe
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [PW-1:0]   pay [STAGES+1];

    assign vld[0]        = s_axis.tvalid;
    assign pay[0]        = in_payload;
    assign s_axis.tready = rdy[0];
    assign m_axis.tvalid = vld[STAGES];
    assign out_payload   = pay[STAGES];
    assign rdy[STAGES]   = m_axis.tready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      state_t        state;
      state_t        state_nx;
      logic [PW-1:0] main_q;
      logic [PW-1:0] skid_q;
      logic          ready_q;
      logic          in_fire;
      logic          out_fire;
      logic          load_main;
      logic          load_skid;
      logic          main_from_skid;

      assign in_fire  = vld[k] & ready_q;
      assign out_fire = (state != EMPTY) & rdy[k+1];

      always_comb begin
        state_nx       = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
          EMPTY: begin
            if (in_fire) begin
              state_nx  = ONE;
              load_main = 1'b1;
            end
          end
          ONE: begin
            if (in_fire && !out_fire) begin
              state_nx  = TWO;
              load_skid = 1'b1;
            end else if (!in_fire && out_fire) begin
              state_nx  = EMPTY;
            end else if (in_fire && out_fire) begin
              load_main = 1'b1;
            end
          end
          TWO: begin
            // ready_q is low here, so only the drain event can occur.
            if (out_fire) begin
              state_nx       = ONE;
              main_from_skid = 1'b1;
            end
          end
          default: state_nx = EMPTY;
        endcase
      end

      always_ff @(posedge aclk) begin
        if (areset) begin
          state   <= EMPTY;
          ready_q <= 1'b0;
        end else begin
          state   <= state_nx;
          ready_q <= (state_nx != TWO);
        end
      end

      always_ff @(posedge aclk) begin
        if (load_main) begin
          main_q <= pay[k];
        end else if (main_from_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= pay[k];
        end
      end

      assign vld[k+1] = (state != EMPTY);
      assign pay[k+1] = main_q;
      assign rdy[k]   = ready_q;
    end

    logic               s_fire;
    logic               m_fire;
    logic [LEVEL_W-1:0] level_q;

    assign s_fire = s_axis.tvalid & s_axis.tready;
    assign m_fire = m_axis.tvalid & m_axis.tready;

    always_ff @(posedge aclk) begin
      if (areset) begin
        level_q <= '0;
      end else if (s_fire && !m_fire) begin
        level_q <= level_q + LEVEL_W'(1);
      end else if (!s_fire && m_fire) begin
        level_q <= level_q - LEVEL_W'(1);
      end
    end

    assign level = level_q;
  end
endmodule

// File: tb/tb_axis_reg_slice.sv
// Bench for axis_reg_slice: five instances (STAGES 0,1,2,3,8) driven by scenario tasks,
// with a queue-based reference of accepted beats and a beat count for level.
module tb_axis_reg_slice;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int IW = 4;
  localparam int DSW = 1;
  localparam int UW = 4;
  localparam int BW = DW + 2 * KW + 1 + IW + DSW + UW;
  localparam int NI = 5;
  localparam int ST [NI] = '{0, 1, 2, 3, 8};

  logic          clk = 1'b0;
  logic          rst     [NI];
  logic          s_valid [NI];
  logic [BW-1:0] s_beat  [NI];
  logic          m_ready [NI];
  logic          s_ready [NI];
  logic          m_valid [NI];
  logic [BW-1:0] m_beat  [NI];
  logic [7:0]    lvl     [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LW = (ST[g] > 0) ? $clog2(2 * ST[g] + 1) : 1;
    axistream_if #(.DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) s_if ();
    axistream_if #(.DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) m_if ();
    logic [LW-1:0] level_w;

    assign s_if.tvalid = s_valid[g];
    assign {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser} = s_beat[g];
    assign m_if.tready = m_ready[g];
    assign s_ready[g]  = s_if.tready;
    assign m_valid[g]  = m_if.tvalid;
    assign m_beat[g]   = {m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser};
    assign lvl[g]      = 8'(level_w);

    axis_reg_slice #(
      .DWIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW), .STAGES(ST[g])
    ) dut (
      .aclk(clk),
      .areset(rst[g]),
      .s_axis(s_if),
      .m_axis(m_if),
      .level(level_w)
    );
  end

  function automatic logic [BW-1:0] mk_beat(input logic [31:0] d, input logic last);
    return {d, 4'hf, 4'hf, last, 4'h0, 1'b0, 4'h0};
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    return {$urandom(), 18'($urandom())};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; s_valid[i] = 1'b1; s_beat[i] = rand_beat(); m_ready[i] = 1'b0;
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 1; i < NI; i++) begin
        checks += 3;
        if (m_valid[i] !== 1'b0) begin failures++; $display("FAIL reset_m_valid[%0d]: got %b want 0", i, m_valid[i]); end
        if (s_ready[i] !== 1'b0) begin failures++; $display("FAIL reset_s_ready[%0d]: got %b want 0", i, s_ready[i]); end
        if (lvl[i] !== 8'd0) begin failures++; $display("FAIL reset_level[%0d]: got %0d want 0", i, lvl[i]); end
      end
    end
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i < NI; i++) begin
      checks += 3;
      if (s_ready[i] !== 1'b1) begin failures++; $display("FAIL release_s_ready[%0d]: got %b want 1", i, s_ready[i]); end
      if (m_valid[i] !== 1'b0) begin failures++; $display("FAIL release_m_valid[%0d]: got %b want 0", i, m_valid[i]); end
      if (lvl[i] !== 8'd0) begin failures++; $display("FAIL release_level[%0d]: got %0d want 0", i, lvl[i]); end
    end
    for (int i = 0; i < NI; i++) s_valid[i] = 1'b0;
  endtask

  task automatic test_wire_through();
    logic          ev;
    logic          er;
    logic [BW-1:0] eb;
    er = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      ev = 1'($urandom_range(0, 1));
      er = ~er;
      eb = rand_beat();
      s_valid[0] = ev; s_beat[0] = eb; m_ready[0] = er;
      #1;
      checks += 4;
      if (m_valid[0] !== ev) begin failures++; $display("FAIL wire_valid: got %b want %b", m_valid[0], ev); end
      if (m_beat[0] !== eb) begin failures++; $display("FAIL wire_payload: got %h want %h", m_beat[0], eb); end
      if (s_ready[0] !== er) begin failures++; $display("FAIL wire_ready: got %b want %b", s_ready[0], er); end
      if (lvl[0] !== 8'd0) begin failures++; $display("FAIL wire_level: got %0d want 0", lvl[0]); end
    end
    s_valid[0] = 1'b0;
  endtask

  task automatic test_streaming();
    int sent = 0, rcvd = 0, cyc = 0, acc_cyc = -1, first_out = -1, last_out = -1;
    m_ready[2] = 1'b1;
    @(posedge clk); #1;
    s_valid[2] = 1'b1; s_beat[2] = mk_beat(32'd0, 1'b0);
    while (rcvd < 16 && cyc < 60) begin
      @(negedge clk);
      checks++;
      if (s_ready[2] !== 1'b1) begin failures++; $display("FAIL stream_s_ready: got %b want 1 cycle %0d", s_ready[2], cyc); end
      if (m_valid[2] === 1'b1) begin
        if (first_out < 0) first_out = cyc;
        else begin
          checks++;
          if (cyc != last_out + 1) begin failures++; $display("FAIL stream_bubble: out at cycle %0d want %0d", cyc, last_out + 1); end
        end
        checks++;
        if (m_beat[2] !== mk_beat(32'(rcvd), rcvd == 15)) begin
          failures++; $display("FAIL stream_beat[%0d]: got %h want %h", rcvd, m_beat[2], mk_beat(32'(rcvd), rcvd == 15));
        end
        rcvd++;
        last_out = cyc;
      end
      if (s_valid[2] && s_ready[2]) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        sent++;
      end
      @(posedge clk); #1;
      if (sent < 16) s_beat[2] = mk_beat(32'(sent), sent == 15);
      else s_valid[2] = 1'b0;
      cyc++;
    end
    checks += 2;
    if (rcvd != 16) begin failures++; $display("FAIL stream_count: got %0d want 16", rcvd); end
    if (first_out - acc_cyc != 2) begin failures++; $display("FAIL stream_latency: got %0d want 2", first_out - acc_cyc); end
    @(negedge clk);
    checks += 2;
    if (lvl[2] !== 8'd0) begin failures++; $display("FAIL stream_level_end: got %0d want 0", lvl[2]); end
    if (m_valid[2] !== 1'b0) begin failures++; $display("FAIL stream_valid_end: got %b want 0", m_valid[2]); end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] exp [3];
    int rcvd = 0, cyc = 0;
    logic c_sent = 1'b0;
    for (int i = 0; i < 3; i++) exp[i] = rand_beat();
    m_ready[1] = 1'b0;
    @(posedge clk); #1;
    s_valid[1] = 1'b1; s_beat[1] = exp[0];
    @(negedge clk);
    checks++;
    if (s_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_accept_a: got %b want 1", s_ready[1]); end
    @(posedge clk); #1;
    s_beat[1] = exp[1];
    @(negedge clk);
    checks++;
    if (s_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_accept_b: got %b want 1", s_ready[1]); end
    @(posedge clk); #1;
    s_beat[1] = exp[2];
    repeat (3) begin
      @(negedge clk);
      checks += 4;
      if (s_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", s_ready[1]); end
      if (lvl[1] !== 8'd2) begin failures++; $display("FAIL bp_full_level: got %0d want 2", lvl[1]); end
      if (m_valid[1] !== 1'b1) begin failures++; $display("FAIL bp_full_valid: got %b want 1", m_valid[1]); end
      if (m_beat[1] !== exp[0]) begin failures++; $display("FAIL bp_hold_a: got %h want %h", m_beat[1], exp[0]); end
      @(posedge clk); #1;
    end
    m_ready[1] = 1'b1;
    while (rcvd < 3 && cyc < 20) begin
      @(negedge clk);
      if (s_valid[1] && s_ready[1]) c_sent = 1'b1;
      if (m_valid[1] === 1'b1) begin
        checks++;
        if (m_beat[1] !== exp[rcvd]) begin failures++; $display("FAIL bp_out[%0d]: got %h want %h", rcvd, m_beat[1], exp[rcvd]); end
        rcvd++;
      end
      @(posedge clk); #1;
      if (c_sent) s_valid[1] = 1'b0;
      cyc++;
    end
    checks++;
    if (rcvd != 3) begin failures++; $display("FAIL bp_count: got %0d want 3", rcvd); end
    @(negedge clk);
    checks++;
    if (lvl[1] !== 8'd0) begin failures++; $display("FAIL bp_level_end: got %0d want 0", lvl[1]); end
  endtask

  task automatic test_mid_reset();
    int acc = 0, cyc = 0, rcvd = 0, sent = 0;
    m_ready[2] = 1'b0;
    @(posedge clk); #1;
    s_valid[2] = 1'b1; s_beat[2] = rand_beat();
    while (acc < 3 && cyc < 20) begin
      @(negedge clk);
      if (s_valid[2] && s_ready[2]) acc++;
      @(posedge clk); #1;
      if (acc == 3) s_valid[2] = 1'b0;
      else s_beat[2] = rand_beat();
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (lvl[2] !== 8'd3) begin failures++; $display("FAIL mrst_level_before: got %0d want 3", lvl[2]); end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    checks += 3;
    if (m_valid[2] !== 1'b0) begin failures++; $display("FAIL mrst_valid: got %b want 0", m_valid[2]); end
    if (lvl[2] !== 8'd0) begin failures++; $display("FAIL mrst_level: got %0d want 0", lvl[2]); end
    if (s_ready[2] !== 1'b0) begin failures++; $display("FAIL mrst_ready: got %b want 0", s_ready[2]); end
    @(posedge clk); #1;
    m_ready[2] = 1'b1; s_valid[2] = 1'b1; s_beat[2] = mk_beat(32'hA0, 1'b0);
    cyc = 0;
    while (cyc < 24) begin
      @(negedge clk);
      if (m_valid[2] === 1'b1) begin
        checks++;
        if (rcvd >= 4) begin failures++; $display("FAIL mrst_extra: got %h want none", m_beat[2]); end
        else if (m_beat[2] !== mk_beat(32'hA0 + 32'(rcvd), rcvd == 3)) begin
          failures++; $display("FAIL mrst_out[%0d]: got %h want %h", rcvd, m_beat[2], mk_beat(32'hA0 + 32'(rcvd), rcvd == 3));
        end
        rcvd++;
      end
      if (s_valid[2] && s_ready[2]) sent++;
      @(posedge clk); #1;
      if (sent < 4) s_beat[2] = mk_beat(32'hA0 + 32'(sent), sent == 3);
      else s_valid[2] = 1'b0;
      cyc++;
    end
    checks++;
    if (rcvd != 4) begin failures++; $display("FAIL mrst_count: got %0d want 4", rcvd); end
  endtask

  task automatic test_random(input int idx);
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] prev_beat = '0;
    logic          stall_prev = 1'b0;
    logic [BW-1:0] want;
    int cap = 2 * ST[idx];
    int sent = 0, rcvd = 0, cnt = 0, cyc = 0;
    logic sf, mf;
    while (rcvd < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      s_valid[idx] = (sent < 10000) && ($urandom_range(0, 7) != 0);
      s_beat[idx]  = rand_beat();
      m_ready[idx] = ((cyc % 512) < 48) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      sf = s_valid[idx] & s_ready[idx];
      mf = m_valid[idx] & m_ready[idx];
      checks++;
      if (lvl[idx] !== 8'(cnt)) begin failures++; $display("FAIL rand%0d_level: got %0d want %0d", ST[idx], lvl[idx], cnt); end
      if (stall_prev) begin
        checks++;
        if (m_valid[idx] !== 1'b1 || m_beat[idx] !== prev_beat) begin
          failures++; $display("FAIL rand%0d_stable: got %b/%h want 1/%h", ST[idx], m_valid[idx], m_beat[idx], prev_beat);
        end
      end
      if (cnt == 0) begin
        checks++;
        if (m_valid[idx] !== 1'b0) begin failures++; $display("FAIL rand%0d_empty_valid: got %b want 0", ST[idx], m_valid[idx]); end
      end
      if (cnt == cap) begin
        checks++;
        if (s_ready[idx] !== 1'b0) begin failures++; $display("FAIL rand%0d_full_ready: got %b want 0", ST[idx], s_ready[idx]); end
      end
      if (mf) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand%0d_spurious: got %h want no beat", ST[idx], m_beat[idx]);
        end else begin
          want = exp_q.pop_front();
          if (m_beat[idx] !== want) begin failures++; $display("FAIL rand%0d_beat[%0d]: got %h want %h", ST[idx], rcvd, m_beat[idx], want); end
        end
        rcvd++;
      end
      if (sf) begin
        exp_q.push_back(s_beat[idx]);
        sent++;
      end
      cnt = cnt + (sf ? 1 : 0) - (mf ? 1 : 0);
      if (cnt > cap) begin
        checks++; failures++;
        $display("FAIL rand%0d_capacity: got %0d want <= %0d", ST[idx], cnt, cap);
        cnt = cap;
      end
      stall_prev = m_valid[idx] & ~m_ready[idx];
      prev_beat  = m_beat[idx];
      cyc++;
    end
    s_valid[idx] = 1'b0;
    m_ready[idx] = 1'b0;
    checks += 2;
    if (rcvd != 10000) begin failures++; $display("FAIL rand%0d_count: got %0d want 10000", ST[idx], rcvd); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand%0d_leftover: got %0d want 0", ST[idx], exp_q.size()); end
  endtask

  initial begin
    #990000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; s_valid[i] = 1'b0; s_beat[i] = '0; m_ready[i] = 1'b0;
    end
    test_reset();
    test_wire_through();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_random(1);
    test_random(3);
    test_random(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
